// File: rtl/multicycle_controller.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/memory/
// writeback for the 5-bit-opcode CPU, with mem_ready stalls, BNE, a sticky
// illegal-opcode trap and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned OP_W     = 5,
  parameter int unsigned FUNCT_W  = 6,
  parameter int unsigned ALUCTL_W = 3,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned OP_RTYPE = 0,
  parameter int unsigned OP_LW    = 1,
  parameter int unsigned OP_SW    = 2,
  parameter int unsigned OP_BEQ   = 3,
  parameter int unsigned OP_BNE   = 4,
  parameter int unsigned OP_ADDI  = 5,
  parameter int unsigned OP_J     = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pcen,
  output logic                irwrite,
  output logic                iord,
  output logic                memread,
  output logic                memwrite,
  output logic                memtoreg,
  output logic                regdst,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          state
);

  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  state_e             state_q, state_d;
  logic               is_sw_q, is_sw_d;
  logic               is_bne_q, is_bne_d;
  logic [CNT_W-1:0]   retired_q;
  logic               retire_c;
  logic               funct_ok_c;
  logic [ALUCTL_W-1:0] funct_alu_c;

  // State, decode flags and retired counter; reset aborts any instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      is_sw_q   <= 1'b0;
      is_bne_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      is_sw_q  <= is_sw_d;
      is_bne_q <= is_bne_d;
      if (retire_c) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // R-type funct to ALU operation; unknown funct flags a trap
  always_comb begin
    funct_ok_c  = 1'b1;
    funct_alu_c = ALU_ADD;
    case (funct)
      FUNCT_W'(6'b100000): funct_alu_c = ALU_ADD;
      FUNCT_W'(6'b100010): funct_alu_c = ALU_SUB;
      FUNCT_W'(6'b100100): funct_alu_c = ALU_AND;
      FUNCT_W'(6'b100101): funct_alu_c = ALU_OR;
      FUNCT_W'(6'b101010): funct_alu_c = ALU_SLT;
      default:             funct_ok_c  = 1'b0;
    endcase
  end

  // Next-state logic; op is captured into flags only in DECODE
  always_comb begin
    state_d  = state_q;
    is_sw_d  = is_sw_q;
    is_bne_d = is_bne_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_sw_d  = (op == OP_W'(OP_SW));
        is_bne_d = (op == OP_W'(OP_BNE));
        if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW))       state_d = S_MEMADR;
        else if (op == OP_W'(OP_RTYPE))                      state_d = S_EXEC;
        else if (op == OP_W'(OP_ADDI))                       state_d = S_ADDIEX;
        else if (op == OP_W'(OP_BEQ) || op == OP_W'(OP_BNE)) state_d = S_BRANCH;
        else if (op == OP_W'(OP_J))                          state_d = S_JUMP;
        else                                                 state_d = S_TRAP;
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC:   state_d = funct_ok_c ? S_ALUWB : S_TRAP;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode; write enables are suppressed while reset is held
  always_comb begin
    pcen       = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu_c;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero ^ is_bne_q;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      memread  = 1'b0;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expectations are queued
// with the stimulus and popped/compared mid-cycle; a second instance with a
// 2-bit counter covers retired wrap-around.
module tb_multicycle_controller;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
    ST_MEMRD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_EXEC = 4'd6,
    ST_ALUWB = 4'd7, ST_ADDIEX = 4'd8, ST_ADDIWB = 4'd9, ST_BRANCH = 4'd10,
    ST_JUMP = 4'd11, ST_TRAP = 4'd12;

  logic clk = 1'b0;
  logic rst_n, zero, mem_ready;
  logic [4:0] op;
  logic [5:0] funct;

  logic pcen, irwrite, iord, memread, memwrite, memtoreg, regdst, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [15:0] retired;
  logic [3:0] state;

  logic w_pcen, w_irwrite, w_iord, w_memread, w_memwrite, w_memtoreg, w_regdst, w_regwrite;
  logic w_alusrca, w_illegal;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_alucontrol;
  logic [1:0] w_retired;
  logic [3:0] w_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .iord(iord), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
    .retired(retired), .state(state)
  );

  multicycle_controller #(.CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(w_pcen), .irwrite(w_irwrite), .iord(w_iord), .memread(w_memread),
    .memwrite(w_memwrite), .memtoreg(w_memtoreg), .regdst(w_regdst), .regwrite(w_regwrite),
    .alusrca(w_alusrca), .alusrcb(w_alusrcb), .pcsrc(w_pcsrc), .alucontrol(w_alucontrol),
    .illegal(w_illegal), .retired(w_retired), .state(w_state)
  );

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [15:0] ret;
    logic [1:0]  ret2;
    logic        rst;
    logic        mr;
    logic        z;
  } exp_t;

  exp_t sb[$];
  logic [15:0] ret_m = '0;
  logic [1:0]  ret2_m = '0;

  // {illegal,pcen,irwrite,iord,memread,memwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,pcsrc,alu}
  function automatic logic [16:0] cv(input logic ill, pc, irw, iod, mrd, mwr, m2r, rdst, rw, asa,
                                     input logic [1:0] asb, psrc, input logic [2:0] alu);
    return {ill, pc, irw, iod, mrd, mwr, m2r, rdst, rw, asa, asb, psrc, alu};
  endfunction

  function automatic logic [16:0] obs_ctrl();
    return {illegal, pcen, irwrite, iord, memread, memwrite, memtoreg, regdst, regwrite,
            alusrca, alusrcb, pcsrc, alucontrol};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue one cycle: inputs to drive plus expected outputs; advance the retire model
  task automatic push(input string tag, input logic [3:0] st, input logic [16:0] ctrl,
                      input logic rst, input logic mr, input logic z, input logic retire);
    exp_t e;
    e.tag = tag; e.st = st; e.ctrl = ctrl; e.ret = ret_m; e.ret2 = ret2_m;
    e.rst = rst; e.mr = mr; e.z = z;
    sb.push_back(e);
    if (!rst) begin
      ret_m = '0;
      ret2_m = '0;
    end else if (retire) begin
      ret_m = ret_m + 16'd1;
      ret2_m = ret2_m + 2'd1;
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rst; mem_ready = e.mr; zero = e.z;
      #1;
      chk({e.tag, "_state"}, 32'(state), 32'(e.st));
      chk({e.tag, "_ctrl"}, 32'(obs_ctrl()), 32'(e.ctrl));
      chk({e.tag, "_retired"}, 32'(retired), 32'(e.ret));
      chk({e.tag, "_retired_w2"}, 32'(w_retired), 32'(e.ret2));
    end
  endtask

  logic [16:0] k_fetch, k_fwait, k_dec, k_madr, k_mrd, k_mrd_rst, k_mwb, k_mwr;
  logic [16:0] k_awb, k_aiex, k_aiwb, k_jmp, k_trap;
  logic [5:0] funct_tab [5];
  logic [2:0] alu_tab [5];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    k_fetch   = cv(0,1,1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010);
    k_fwait   = cv(0,0,0,0,1,0,0,0,0,0,2'b01,2'b00,3'b010);
    k_dec     = cv(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010);
    k_madr    = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
    k_mrd     = cv(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b010);
    k_mrd_rst = cv(0,0,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010);
    k_mwb     = cv(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010);
    k_mwr     = cv(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00,3'b010);
    k_awb     = cv(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010);
    k_aiex    = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
    k_aiwb    = cv(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010);
    k_jmp     = cv(0,1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b010);
    k_trap    = cv(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010);
    funct_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    alu_tab   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    rst_n = 1'b0; op = 5'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    // Reset held two cycles: no write enables
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_enables", 32'({pcen, irwrite, memwrite, regwrite, memread}), 32'd0);
      chk("rst_enables_w2", 32'({w_pcen, w_irwrite, w_memwrite, w_regwrite, w_memread}), 32'd0);
    end

    // R-type for each legal funct
    for (int i = 0; i < 5; i++) begin
      op = 5'd0; funct = funct_tab[i];
      push("rt_fetch", ST_FETCH, k_fetch, 1, 1, 0, 0);
      push("rt_decode", ST_DECODE, k_dec, 1, 1, 0, 0);
      push("rt_exec", ST_EXEC, cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,alu_tab[i]), 1, 1, 0, 0);
      push("rt_aluwb", ST_ALUWB, k_awb, 1, 1, 0, 1);
      drain();
    end

    // LW with two wait cycles in MEMRD
    op = 5'd1;
    push("lw_fetch", ST_FETCH, k_fetch, 1, 1, 0, 0);
    push("lw_decode", ST_DECODE, k_dec, 1, 1, 0, 0);
    push("lw_memadr", ST_MEMADR, k_madr, 1, 1, 0, 0);
    push("lw_memrd0", ST_MEMRD, k_mrd, 1, 0, 0, 0);
    push("lw_memrd1", ST_MEMRD, k_mrd, 1, 0, 0, 0);
    push("lw_memrd2", ST_MEMRD, k_mrd, 1, 1, 0, 0);
    push("lw_memwb", ST_MEMWB, k_mwb, 1, 1, 0, 1);
    drain();

    // SW with a fetch stall and a write stall; mem_ready low elsewhere is ignored
    op = 5'd2;
    push("sw_fwait", ST_FETCH, k_fwait, 1, 0, 0, 0);
    push("sw_fetch", ST_FETCH, k_fetch, 1, 1, 0, 0);
    push("sw_decode", ST_DECODE, k_dec, 1, 0, 0, 0);
    push("sw_memadr", ST_MEMADR, k_madr, 1, 0, 0, 0);
    push("sw_memwr0", ST_MEMWR, k_mwr, 1, 0, 0, 0);
    push("sw_memwr1", ST_MEMWR, k_mwr, 1, 1, 0, 1);
    drain();

    // ADDI
    op = 5'd5;
    push("addi_fetch", ST_FETCH, k_fetch, 1, 1, 0, 0);
    push("addi_decode", ST_DECODE, k_dec, 1, 1, 0, 0);
    push("addi_ex", ST_ADDIEX, k_aiex, 1, 1, 0, 0);
    push("addi_wb", ST_ADDIWB, k_aiwb, 1, 1, 0, 1);
    drain();

    // BEQ/BNE with zero = 1 and 0
    for (int i = 0; i < 4; i++) begin
      logic bne, z;
      bne = (i >= 2); z = ~i[0];
      op = bne ? 5'd4 : 5'd3;
      push("br_fetch", ST_FETCH, k_fetch, 1, 1, ~z, 0);
      push("br_decode", ST_DECODE, k_dec, 1, 1, ~z, 0);
      push(bne ? "bne_branch" : "beq_branch", ST_BRANCH,
           cv(0, bne ? ~z : z, 0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110), 1, 1, z, 1);
      drain();
    end

    // J
    op = 5'd6;
    push("j_fetch", ST_FETCH, k_fetch, 1, 1, 0, 0);
    push("j_decode", ST_DECODE, k_dec, 1, 1, 0, 0);
    push("j_jump", ST_JUMP, k_jmp, 1, 1, 0, 1);
    drain();

    // LW aborted by reset in MEMRD, then a full LW after reset
    op = 5'd1;
    push("ab_fetch", ST_FETCH, k_fetch, 1, 1, 0, 0);
    push("ab_decode", ST_DECODE, k_dec, 1, 1, 0, 0);
    push("ab_memadr", ST_MEMADR, k_madr, 1, 1, 0, 0);
    push("ab_memrd_rst", ST_MEMRD, k_mrd_rst, 0, 1, 0, 0);
    push("ab_fetch2", ST_FETCH, k_fetch, 1, 1, 0, 0);
    push("ab_decode2", ST_DECODE, k_dec, 1, 1, 0, 0);
    push("ab_memadr2", ST_MEMADR, k_madr, 1, 1, 0, 0);
    push("ab_memrd2", ST_MEMRD, k_mrd, 1, 1, 0, 0);
    push("ab_memwb2", ST_MEMWB, k_mwb, 1, 1, 0, 1);
    drain();

    // Illegal opcode: sticky trap, then reset clears it
    op = 5'd7;
    push("ill_fetch", ST_FETCH, k_fetch, 1, 1, 0, 0);
    push("ill_decode", ST_DECODE, k_dec, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) push("ill_trap", ST_TRAP, k_trap, 1, i[0], i[1], 0);
    push("ill_trap_rst", ST_TRAP, k_trap, 0, 1, 0, 0);
    drain();

    // Illegal funct: trap after EXEC
    op = 5'd0; funct = 6'b000000;
    push("if_fetch", ST_FETCH, k_fetch, 1, 1, 0, 0);
    push("if_decode", ST_DECODE, k_dec, 1, 1, 0, 0);
    push("if_exec", ST_EXEC, cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010), 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) push("if_trap", ST_TRAP, k_trap, 1, 1, 0, 0);
    push("if_trap_rst", ST_TRAP, k_trap, 0, 1, 0, 0);
    drain();

    // Five jumps from a cleared counter: 2-bit instance wraps 1,2,3,0,1
    op = 5'd6;
    for (int i = 0; i < 5; i++) begin
      push("wr_fetch", ST_FETCH, k_fetch, 1, 1, 0, 0);
      push("wr_decode", ST_DECODE, k_dec, 1, 1, 0, 0);
      push("wr_jump", ST_JUMP, k_jmp, 1, 1, 0, 1);
    end
    push("wr_final", ST_FETCH, k_fetch, 1, 1, 0, 0);
    drain();
    chk("wrap_final_w2", 32'(w_retired), 32'd1);
    chk("wrap_final", 32'(retired), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control unit for the 5-bit-opcode CPU; it replaces the single-cycle opcode/ALU decoder pair with a parametrised Moore FSM. It sequences fetch, decode, execute, memory and writeback over multiple cycles, and stalls on a memory-ready handshake. It also adds BNE, a sticky illegal-opcode trap and a retired-instruction counter. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- OP_W, 5: opcode width
- FUNCT_W, 6: R-type funct width
- ALUCTL_W, 3: ALU control width
- CNT_W, 16: retired-instruction counter width
- OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_BNE/OP_ADDI/OP_J, 0/1/2/3/4/5/6: opcode encodings

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- op  in  OP_W  opcode from instruction register
- funct  in  FUNCT_W  funct field from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pcen  out  1  PC write enable (pcwrite | branch-taken)
- irwrite  out  1  instruction register load
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread, memwrite  out  1 each  memory strobes
- memtoreg, regdst, regwrite  out  1 each  register-file controls
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 = rt, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  sticky illegal-opcode/funct flag
- retired  out  CNT_W  count of completed instructions
- state  out  4  current FSM state (debug)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, add.
  - If mem_ready: irwrite=1 and pcen=1 in the same cycle, then go to DECODE.
  - Otherwise hold FETCH with irwrite=pcen=0.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - LW/SW → MEMADR
  - RTYPE → EXEC
  - ADDI → ADDIEX
  - BEQ/BNE → BRANCH
  - J → JUMP
  - any other op → TRAP
- MEMADR: alusrca=1, alusrcb=10, add. Next: LW → MEMRD, SW → MEMWR.
- MEMRD: memread=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Retire, then go to FETCH.
- MEMWR: memwrite=1, iord=1. Hold until mem_ready; retire in the mem_ready cycle, then go to FETCH.
- EXEC: alusrca=1, alusrcb=00. alucontrol by funct:
  - 100000 → add
  - 100010 → sub
  - 100100 → and
  - 100101 → or
  - 101010 → slt
  - other funct → TRAP next cycle instead of ALUWB
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Retire, then go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next: ADDIWB.
- ADDIWB: regwrite=1, regdst=0. Retire, then go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero for BEQ, ~zero for BNE.
  - Retire, then go to FETCH.
- JUMP: pcsrc=10, pcen=1. Retire, then go to FETCH.
- TRAP: all enables 0; illegal=1. Stays in TRAP until reset; retired is frozen.
- Defaults: every output not listed for a state is 0, including alucontrol=010 (add).
- retired: increments by 1 in each retiring cycle and wraps modulo 2^CNT_W.

## Timing
- Moore outputs, decoded from `state` only. The exception is pcen in BRANCH, which is combinational on zero.
- While rst_n=0 (sampled at the edge):
  - next state is FETCH; retired clears to 0; illegal clears to 0.
  - all write enables are forced 0 combinationally (pcen, irwrite, memwrite, regwrite, memread).
- Reset asserted mid-instruction aborts the instruction with no retire; the first post-reset cycle is FETCH.
- Latency with mem_ready always 1, in cycles:
  - LW = 5
  - SW = 4
  - R-type = 4
  - ADDI = 4
  - BEQ/BNE = 3
  - J = 3
- Each wait cycle on mem_ready adds one cycle. mem_ready is ignored in states without a memory access.
- op and funct are sampled only in DECODE and EXEC respectively. The instruction register holds them stable after FETCH.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, release → state=FETCH, retired=0, illegal=0, and no write enables during reset.
- R-type add (op=0, funct=100000), mem_ready=1 → states FETCH, DECODE, EXEC, ALUWB; regwrite=1 and regdst=1 in cycle 4; retired=1.
- LW with mem_ready low for 2 cycles in MEMRD → MEMRD held 3 cycles, total 7 cycles; memtoreg=1 only in MEMWB.
- BEQ with zero=1 → pcen=1 in BRANCH. BNE with zero=1 → pcen=0. Both retire after 3 cycles.
- op=7 → TRAP after DECODE; illegal=1 held for 10+ cycles; retired unchanged; rst_n=0 for 1 cycle clears illegal and returns to FETCH.
- Counter wrap: CNT_W=2, run 5 J instructions → retired sequence 1, 2, 3, 0, 1.
